// File: rtl/cnn_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cnn_pkg
//  Description : Shared constants and helpers for the CNN datapath stages
//                (sample format, layer-4 feature-map geometry, signed max).
//  Revision    : 1.0  initial release
// ============================================================================
package cnn_pkg;

    // Fixed-point sample width used between layers
    localparam int Q_DATA_W = 18;

    // Layer-4 conv2d output geometry
    localparam int L4_W = 16;
    localparam int L4_H = 16;
    localparam int L4_C = 32;

    // Signed max select: 1 when a is the maximum of (a, b). Operands are
    // sign-extended to 64 bits by the caller so one helper serves any width.
    function automatic logic smax_sel_a(input logic signed [63:0] a,
                                        input logic signed [63:0] b);
        return (a >= b);
    endfunction

endpackage
`default_nettype wire

// File: rtl/maxpool_line_buf.sv
`default_nettype none
// ============================================================================
//  Module      : maxpool_line_buf
//  Description : Half-width line buffer holding horizontal-pair maxima of the
//                even input row. Synchronous write, asynchronous read, no
//                reset on the storage.
//  Revision    : 1.0  initial release
// ============================================================================
module maxpool_line_buf #(
    parameter int DEPTH  = 8,
    parameter int DATA_W = 18,
    parameter int AW     = 3
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [AW-1:0]            waddr,
    input  logic signed [DATA_W-1:0] wdata,
    input  logic [AW-1:0]            raddr,
    output logic signed [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH];

    // Store one pair maximum per accepted odd-column beat of an even row
    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[waddr] <= wdata;
        end
    end

    assign rdata = r_mem[raddr];

endmodule
`default_nettype wire

// File: rtl/maxpool2d_2x2_stream.sv
`default_nettype none
// ============================================================================
//  Module      : maxpool2d_2x2_stream
//  Description : Streaming 2x2 / stride-2 signed max-pool. One sample per
//                beat, planes in sequence, raster order within a plane.
//                Single registered output stage with valid/ready on both
//                sides; frames may follow each other with no gap.
//  Revision    : 1.0  initial release
// ============================================================================
module maxpool2d_2x2_stream
    import cnn_pkg::*;
#(
    parameter int WIDTH    = L4_W,
    parameter int HEIGHT   = L4_H,
    parameter int CHANNELS = L4_C,
    parameter int DATA_W   = Q_DATA_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DATA_W-1:0] in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [DATA_W-1:0] out_data,
    output logic                     out_last
);

    localparam int c_COL_W    = (WIDTH    > 1) ? $clog2(WIDTH)    : 1;
    localparam int c_ROW_W    = (HEIGHT   > 1) ? $clog2(HEIGHT)   : 1;
    localparam int c_CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int c_LB_DEPTH = WIDTH / 2;
    localparam int c_LB_AW    = (c_LB_DEPTH > 1) ? $clog2(c_LB_DEPTH) : 1;

    localparam logic [c_COL_W-1:0] c_COL_LAST = c_COL_W'(WIDTH - 1);
    localparam logic [c_ROW_W-1:0] c_ROW_LAST = c_ROW_W'(HEIGHT - 1);
    localparam logic [c_CH_W-1:0]  c_CH_LAST  = c_CH_W'(CHANNELS - 1);

    localparam logic [0:0] c_ROW_EVEN = 1'b0;
    localparam logic [0:0] c_ROW_ODD  = 1'b1;

    // Odd plane dimensions cannot be pooled 2x2; refuse to elaborate
    if ((WIDTH % 2) != 0 || WIDTH < 2) begin : g_bad_width
        $error("maxpool2d_2x2_stream: WIDTH must be even and >= 2");
    end
    if ((HEIGHT % 2) != 0 || HEIGHT < 2) begin : g_bad_height
        $error("maxpool2d_2x2_stream: HEIGHT must be even and >= 2");
    end

    logic [c_COL_W-1:0]       r_col;
    logic [c_ROW_W-1:0]       r_row;
    logic [c_CH_W-1:0]        r_ch;
    logic [0:0]               r_state;
    logic [0:0]               w_state_nxt;
    logic signed [DATA_W-1:0] r_hreg;
    logic                     r_out_valid;
    logic signed [DATA_W-1:0] r_out_data;
    logic                     r_out_last;

    logic                     w_in_ready;
    logic                     w_accept;
    logic                     w_odd_col;
    logic                     w_col_last;
    logic                     w_row_last;
    logic                     w_ch_last;
    logic                     w_lb_we;
    logic                     w_load;
    logic                     w_frame_end;
    logic [c_LB_AW-1:0]       w_lb_addr;
    logic signed [DATA_W-1:0] w_lb_rdata;
    logic signed [DATA_W-1:0] w_hmax;
    logic signed [DATA_W-1:0] w_pmax;

    // Accept only when the output register is empty or draining this cycle
    assign w_in_ready = !r_out_valid || out_ready;
    assign w_accept   = in_valid && w_in_ready;

    assign w_odd_col   = r_col[0];
    assign w_col_last  = (r_col == c_COL_LAST);
    assign w_row_last  = (r_row == c_ROW_LAST);
    assign w_ch_last   = (r_ch  == c_CH_LAST);
    assign w_frame_end = w_ch_last && w_row_last && w_col_last;
    assign w_lb_addr   = c_LB_AW'(r_col >> 1);

    assign w_hmax = smax_sel_a(64'(r_hreg), 64'(in_data)) ? r_hreg : in_data;
    assign w_pmax = smax_sel_a(64'(w_hmax), 64'(w_lb_rdata)) ? w_hmax : w_lb_rdata;

    assign w_lb_we = w_accept && w_odd_col && (r_state == c_ROW_EVEN);
    assign w_load  = w_accept && w_odd_col && (r_state == c_ROW_ODD);

    maxpool_line_buf #(
        .DEPTH  (c_LB_DEPTH),
        .DATA_W (DATA_W),
        .AW     (c_LB_AW)
    ) u_line_buf (
        .clk   (clk),
        .we    (w_lb_we),
        .waddr (w_lb_addr),
        .wdata (w_hmax),
        .raddr (w_lb_addr),
        .rdata (w_lb_rdata)
    );

    // Position counters: col -> row -> channel, advancing on accepted beats
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_col <= '0;
            r_row <= '0;
            r_ch  <= '0;
        end else if (w_accept) begin
            if (w_col_last) begin
                r_col <= '0;
                if (w_row_last) begin
                    r_row <= '0;
                    r_ch  <= w_ch_last ? '0 : r_ch + 1'b1;
                end else begin
                    r_row <= r_row + 1'b1;
                end
            end else begin
                r_col <= r_col + 1'b1;
            end
        end
    end

    // Hold the even-column sample until its odd-column partner arrives
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hreg <= '0;
        end else if (w_accept && !w_odd_col) begin
            r_hreg <= in_data;
        end
    end

    // Row-parity state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_ROW_EVEN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Row-parity next state: flip on the last accepted beat of each row
    always_comb begin
        w_state_nxt = r_state;
        if (w_accept && w_col_last) begin
            case (r_state)
                c_ROW_EVEN: w_state_nxt = c_ROW_ODD;
                c_ROW_ODD:  w_state_nxt = c_ROW_EVEN;
                default:    w_state_nxt = c_ROW_EVEN;
            endcase
        end
    end

    // Output stage: load a new pooled value, else drain on acceptance
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_last  <= 1'b0;
        end else if (w_load) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_pmax;
            r_out_last  <= w_frame_end;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_last  = r_out_last;

endmodule
`default_nettype wire

// File: doc/maxpool2d_2x2_stream.md
# maxpool2d_2x2_stream

Streaming 2×2/stride-2 max-pool stage that consumes the ReLU'd output of the fourth conv2d layer (16×16×32, 18-bit signed fixed-point) and produces 8×8×32 pooled maps for the next layer. Input arrives one value per beat, channel plane after channel plane, raster order inside each plane. A half-width line buffer holds horizontal-pair maxima from even rows. Valid/ready handshakes on both sides allow back-pressure from the downstream consumer.

## Interface
- `WIDTH`, 16, input plane width; must be even (elaboration error otherwise)
- `HEIGHT`, 16, input plane height; must be even
- `CHANNELS`, 32, planes per frame
- `DATA_W`, 18, signed sample width (input and output)
- Clock and reset: one clock; reset is asynchronous and active-high.
- `clk`  in  1  rising-edge clock
- `rst`  in  1  asynchronous, active-high reset
- `in_valid`  in  1  input sample valid
- `in_ready`  out  1  stage can accept a sample this cycle
- `in_data`  in  DATA_W  signed input sample
- `out_valid`  out  1  pooled sample valid
- `out_ready`  in  1  downstream accepts this cycle
- `out_data`  out  DATA_W  signed pooled maximum
- `out_last`  out  1  high with the final pooled sample of the frame (plane CHANNELS-1, pooled position (H/2-1, W/2-1))

## Operation
- An input beat is accepted when `in_valid && in_ready`. An output beat is accepted when `out_valid && out_ready`.
- Counters advance only on accepted input beats:
  - `col` wraps at WIDTH-1 and increments `row`.
  - `row` wraps at HEIGHT-1 and increments `ch`.
  - `ch` wraps at CHANNELS-1 back to 0, so frames are back-to-back with no gap.
- Even `col`: the sample is captured into the pair register `hreg`.
- Odd `col`: `hmax = max(hreg, in_data)`, signed compare. The winner on a tie is irrelevant because the values are equal.
- Row state FSM:
  - `ROW_EVEN`: `hmax` is written to `linebuf[col>>1]`. Transitions to `ROW_ODD` on the accepted beat with `col == WIDTH-1`.
  - `ROW_ODD`: `pmax = max(hmax, linebuf[col>>1])` is loaded into `out_data`, and `out_valid` is set. Transitions to `ROW_EVEN` on the accepted beat with `col == WIDTH-1`.
- `out_last` is loaded together with `out_data`. It is 1 iff `ch == CHANNELS-1`, `row == HEIGHT-1` and `col == WIDTH-1`.
- `in_ready = !out_valid || out_ready`. The rule is global and identical in every state, which keeps the output a single registered stage with no drops.
- `out_valid` clears on output acceptance unless a new pooled value is loaded in the same cycle, in which case it stays 1 with the new data.
- No saturation or rescaling: the output is an exact copy of one input sample. The line buffer is WIDTH/2 × DATA_W.

## Timing
- Reset values:
  - `out_valid=0`, `out_data=0`, `out_last=0`
  - `col=row=ch=0`, `hreg=0`, FSM=`ROW_EVEN`
  - `in_ready=1` from the first cycle after reset release
  - Line-buffer contents are don't-care.
- Latency: `out_valid` rises on the clock edge that accepts the odd-row, odd-col input, so the output is visible 1 cycle after that input beat.
- Throughput: 1 input/cycle sustained when `out_ready=1`, giving 1 output per 4 inputs. Output frame = WIDTH/2 × HEIGHT/2 × CHANNELS = 2048 beats.
- Back-pressure: while `out_valid && !out_ready`, `in_ready=0`. No counter, `hreg` or line-buffer update happens in those cycles.
- `in_valid` low: hold all state; bubbles anywhere in the stream are legal.
- Reset mid-frame: the partial frame is discarded and any pending `out_valid` is dropped. The next accepted beat is treated as (ch 0, row 0, col 0).
- Line-buffer read and write both happen in the accepting cycle. Read is combinational or same-edge write-first is not required: even rows write and odd rows read, never the same row.

## Structure
- Shared package `cnn_pkg`:
  - sample width constant `Q_DATA_W=18`
  - layer-4 dimensions `L4_W=16`, `L4_H=16`, `L4_C=32`
  - signed max helper function
- One sub-module, `maxpool_line_buf`:
  - WIDTH/2-deep, DATA_W-wide register array
  - synchronous write, asynchronous read
  - no reset on contents
- Top level holds the counters, FSM, `hreg` and the output register.

## Test plan
- **Single 4×4×1 plane (params overridden)**, input 0..15 raster, `out_ready=1` -> outputs 5, 7, 13, 15; `out_last` only on 15.
- **Negative values**, 2×2 block {-5, -3, -9, -4} -> output -3, proving a signed compare.
- **Back-pressure**, `out_ready=0` for 10 cycles while the output is pending -> `in_ready=0` throughout, `out_data` stable, no input lost. The full sequence matches the no-stall run.
- **Random `in_valid` bubbles and random `out_ready`** over a full 16×16×32 frame -> 2048 outputs. They match a max-pool of the golden `04_conv2d_w_br/feature_map_*.txt` files, and `out_last` appears exactly once.
- **Reset asserted after 100 beats** -> next cycle `out_valid=0`, `in_ready=1`. A full frame restarted from zero pools correctly.
- **Two frames back-to-back** with no gap -> the second frame's first output is the max of plane 0, block (0,0) of frame 2, and `out_last` fires twice.
